// File: rtl/xlr8_ana_pin_seq.sv
// Analog-pin isolation sequencer: isolates the selected A0-A5 pin (and the I2C pullups for
// A4/A5), waits a settle time, runs one ADC conversion and then restores the pins.
module xlr8_ana_pin_seq #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       Clock,
  input  logic       RESET_N,
  input  logic       i2c_en_req,
  input  logic       conv_req,
  input  logic [2:0] conv_chan,
  input  logic       adc_done,
  output logic       adc_start,
  output logic       conv_busy,
  output logic       conv_done,
  output logic       conv_err,
  output logic       I2C_ENABLE,
  output logic [5:0] dig_disc
);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StStart,
    StWait,
    StRelease
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [16:0] tmo_q, tmo_d;
  logic        ok_q, ok_d;
  logic [5:0]  disc_q, disc_d;
  logic        i2c_q, i2c_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    ok_d     = ok_q;
    disc_d   = disc_q;

    unique case (state_q)
      StIdle: begin
        if (conv_req) begin
          if (conv_chan < 3'd6) begin
            state_d  = StSettle;
            settle_d = 8'(SETTLE_CYCLES - 1);
            disc_d   = 6'd1 << conv_chan;
          end else begin
            state_d = StStart;
          end
        end
      end
      StSettle: begin
        if (settle_q == 8'd0) begin
          state_d = StStart;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      StStart: begin
        state_d = StWait;
        tmo_d   = '0;
      end
      StWait: begin
        // The entry cycle is not counted, so WAIT spans up to TIMEOUT_CYCLES+1 cycles.
        // A done on the terminal cycle still counts as a normal completion.
        if (adc_done) begin
          state_d = StRelease;
          ok_d    = 1'b1;
          disc_d  = '0;
        end else if (tmo_q == 17'(TIMEOUT_CYCLES)) begin
          state_d = StRelease;
          ok_d    = 1'b0;
          disc_d  = '0;
        end else begin
          tmo_d = tmo_q + 17'd1;
        end
      end
      StRelease: begin
        state_d = StIdle;
        disc_d  = '0;
      end
      default: begin
        state_d = StIdle;
        disc_d  = '0;
      end
    endcase

    // Pullups stay off for as long as A4 or A5 is isolated.
    i2c_d   = i2c_en_req & ~(disc_d[4] | disc_d[5]);
    start_d = (state_d == StStart);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StRelease) & ok_d;
    err_d   = (state_d == StRelease) & ~ok_d;
  end

  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      settle_q <= '0;
      tmo_q    <= '0;
      ok_q     <= 1'b0;
      disc_q   <= '0;
      i2c_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      ok_q     <= ok_d;
      disc_q   <= disc_d;
      i2c_q    <= i2c_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign adc_start  = start_q;
  assign conv_busy  = busy_q;
  assign conv_done  = done_q;
  assign conv_err   = err_q;
  assign I2C_ENABLE = i2c_q;
  assign dig_disc   = disc_q;

endmodule

// File: tb/tb_xlr8_ana_pin_seq.sv
// Self-checking bench for xlr8_ana_pin_seq: directed table rows, reset corner cases and
// randomized transactions checked cycle by cycle against a timeline model.
module tb_xlr8_ana_pin_seq;

  localparam int S = 16;
  localparam int T = 8;

  logic       Clock = 1'b0;
  logic       RESET_N = 1'b1;
  logic       i2c_en_req = 1'b0;
  logic       conv_req = 1'b0;
  logic [2:0] conv_chan = 3'd0;
  logic       adc_done = 1'b0;
  logic       adc_start, conv_busy, conv_done, conv_err, I2C_ENABLE;
  logic [5:0] dig_disc;

  int   vectors = 0;
  int   miscompares = 0;
  logic prev_en = 1'b0;

  typedef struct {
    int chan;
    int d;        // adc_done this many cycles after adc_start; 0 = never
    int en_mode;  // 0/1 fixed i2c_en_req level, 2 random per cycle
    int noise;    // spurious conv_req / adc_done outside WAIT
    int exp_start;
    int exp_rel;
    int exp_ok;
  } vec_t;

  vec_t tbl[8];

  xlr8_ana_pin_seq #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .Clock     (Clock),
    .RESET_N   (RESET_N),
    .i2c_en_req(i2c_en_req),
    .conv_req  (conv_req),
    .conv_chan (conv_chan),
    .adc_done  (adc_done),
    .adc_start (adc_start),
    .conv_busy (conv_busy),
    .conv_done (conv_done),
    .conv_err  (conv_err),
    .I2C_ENABLE(I2C_ENABLE),
    .dig_disc  (dig_disc)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [10:0] pack(input logic start, input logic busy, input logic done,
                                       input logic err, input logic i2c, input logic [5:0] disc);
    return {start, busy, done, err, i2c, disc};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {adc_start, conv_busy, conv_done, conv_err, I2C_ENABLE, dig_disc};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: start/busy/done/err/i2c/disc got %b required %b", name, act, exp);
    end
  endtask

  task automatic drive_en(input int mode);
    if (mode == 2) i2c_en_req = 1'($urandom_range(0, 1));
    else i2c_en_req = (mode == 1);
    prev_en = i2c_en_req;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      drive_en(2);
      conv_req = 1'b0;
      adc_done = 1'($urandom_range(0, 1));
      step();
      check(name, pack(1'b0, 1'b0, 1'b0, 1'b0, prev_en, 6'd0));
    end
    adc_done = 1'b0;
  endtask

  // One conversion, checked every cycle from the request until the block is idle again.
  task automatic run_txn(input int chan, input int d, input int en_mode, input int noise,
                         input int start_k, input int rel, input int ok, input string name);
    logic       pin;
    logic       hold;
    logic [5:0] onehot;
    logic [5:0] disc;
    pin    = (chan < 6);
    onehot = pin ? (6'd1 << chan) : 6'd0;
    conv_req  = 1'b1;
    conv_chan = 3'(chan);
    adc_done  = 1'b0;
    drive_en(en_mode);
    step();
    conv_req = 1'b0;
    for (int k = 1; k <= rel + 1; k++) begin
      hold = pin && (chan >= 4) && (k < rel);
      disc = (pin && k < rel) ? onehot : 6'd0;
      check($sformatf("%s k=%0d", name, k),
            pack(k == start_k, k <= rel, (k == rel) && (ok != 0), (k == rel) && (ok == 0),
                 hold ? 1'b0 : prev_en, disc));
      if (k <= rel) begin
        drive_en(en_mode);
        adc_done = (d != 0 && k == start_k + d) ||
                   (noise != 0 && (k == rel || (k <= start_k && $urandom_range(0, 2) == 0)));
        conv_req  = (noise != 0) && ($urandom_range(0, 2) == 0);
        conv_chan = 3'($urandom_range(0, 7));
        step();
      end
    end
    conv_req = 1'b0;
    adc_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int chan, d, start_k, rel;

    tbl[0] = '{2, 5, 1, 0, 17, 23, 1};  // adc_done 5 after start, pullups stay on
    tbl[1] = '{5, 3, 1, 0, 17, 21, 1};  // A5: pullups dropped until release
    tbl[2] = '{7, 2, 1, 1, 1, 4, 1};    // internal channel, repeat requests ignored
    tbl[3] = '{0, 0, 0, 1, 17, 27, 0};  // timeout, late adc_done ignored
    tbl[4] = '{6, 0, 2, 1, 1, 11, 0};
    tbl[5] = '{4, 9, 2, 1, 17, 27, 1};  // done on the terminal cycle wins
    tbl[6] = '{3, 1, 2, 1, 17, 19, 1};
    tbl[7] = '{1, 4, 2, 1, 17, 22, 1};

    // Reset with i2c_en_req held high
    i2c_en_req = 1'b1;
    prev_en    = 1'b1;
    #2 RESET_N = 1'b0;
    #10 check("reset", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    #1 RESET_N = 1'b1;
    #1 check("post_reset_pre_clk", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    step();
    check("first_clk", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
    idle(3, "idle");

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].chan, tbl[i].d, tbl[i].en_mode, tbl[i].noise, tbl[i].exp_start,
              tbl[i].exp_rel, tbl[i].exp_ok, $sformatf("vec%0d", i));
      idle(2, $sformatf("vec%0d_gap", i));
    end

    // Reset dropped mid-SETTLE on A4
    conv_req  = 1'b1;
    conv_chan = 3'd4;
    drive_en(1);
    step();
    conv_req = 1'b0;
    step();
    step();
    check("rst_mid_settle", pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b010000));
    #2 RESET_N = 1'b0;
    #1 check("rst_async", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    for (int i = 0; i < 20; i++) begin
      step();
      check("rst_held", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    end
    RESET_N = 1'b1;
    idle(2, "rst_after");
    run_txn(4, 2, 1, 0, 17, 20, 1, "rst_fresh");
    idle(1, "rst_fresh_gap");

    // Randomized transactions against the timeline model
    for (int i = 0; i < 24; i++) begin
      chan    = $urandom_range(0, 7);
      d       = $urandom_range(0, T + 1);
      start_k = (chan < 6) ? S + 1 : 1;
      rel     = (d != 0) ? start_k + d + 1 : start_k + T + 2;
      run_txn(chan, d, 2, 1, start_k, rel, (d != 0) ? 1 : 0, $sformatf("rnd%0d", i));
      idle($urandom_range(0, 3), $sformatf("rnd%0d_gap", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
